// File: rtl/box_raster_engine.sv
// Box raster engine: accepts one square-draw command and streams its pixels,
// one per clock, to the vga_adapter, clipping anything outside the frame.
module box_raster_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SIZE_W   = 5
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_x,
  input  logic [6:0]        cmd_y,
  input  logic [SIZE_W-1:0] cmd_size,
  input  logic [2:0]        cmd_colour,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [8:0]        W_LIM = 9'(SCREEN_W);
  localparam logic [7:0]        H_LIM = 8'(SCREEN_H);
  localparam logic [SIZE_W-1:0] ONE   = SIZE_W'(1);

  state_t state, state_n;

  logic [7:0]        ox, ox_n;
  logic [6:0]        oy, oy_n;
  logic [SIZE_W-1:0] sz, sz_n;
  logic [2:0]        col, col_n;
  logic [SIZE_W-1:0] dx, dx_n;
  logic [SIZE_W-1:0] dy, dy_n;
  logic [SIZE_W-1:0] last;
  logic              accept;

  logic [8:0] px;
  logic [7:0] py;
  logic [7:0] x_n;
  logic [6:0] y_n;
  logic [2:0] colour_n;
  logic       plot_n;
  logic       busy_n;
  logic       done_n;

  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign last      = sz - ONE;

  // State register; the counters always point at the pixel currently on the outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and scan-counter logic: latch on accept, then raster left-to-right, top-to-bottom.
  always_comb begin
    state_n = state;
    ox_n    = ox;
    oy_n    = oy;
    sz_n    = sz;
    col_n   = col;
    dx_n    = dx;
    dy_n    = dy;
    case (state)
      IDLE: begin
        if (accept) begin
          ox_n    = cmd_x;
          oy_n    = cmd_y;
          sz_n    = cmd_size;
          col_n   = cmd_colour;
          dx_n    = '0;
          dy_n    = '0;
          state_n = (cmd_size == '0) ? DONE : DRAW;
        end
      end
      DRAW: begin
        if (dx == last && dy == last) begin
          state_n = DONE;
        end else if (dx == last) begin
          dx_n = '0;
          dy_n = dy + ONE;
        end else begin
          dx_n = dx + ONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the registered outputs line up with that state.
  always_comb begin
    px       = {1'b0, ox_n} + 9'(dx_n);
    py       = {1'b0, oy_n} + 8'(dy_n);
    x_n      = '0;
    y_n      = '0;
    colour_n = '0;
    plot_n   = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    case (state_n)
      DRAW: begin
        x_n      = px[7:0];
        y_n      = py[6:0];
        colour_n = col_n;
        plot_n   = (px < W_LIM) && (py < H_LIM);
        busy_n   = 1'b1;
      end
      DONE: begin
        busy_n = 1'b1;
        done_n = 1'b1;
      end
      default: begin
        busy_n = 1'b0;
      end
    endcase
  end

  // Latched command and scan counters.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ox  <= '0;
      oy  <= '0;
      sz  <= '0;
      col <= '0;
      dx  <= '0;
      dy  <= '0;
    end else begin
      ox  <= ox_n;
      oy  <= oy_n;
      sz  <= sz_n;
      col <= col_n;
      dx  <= dx_n;
      dy  <= dy_n;
    end
  end

  // Registered pixel outputs towards the vga_adapter.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      x      <= x_n;
      y      <= y_n;
      colour <= colour_n;
      plot   <= plot_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: doc/box_raster_engine.md
Name: box_raster_engine

Overview:
Sequential rasteriser between the per-screen coordinate generators and the single vga_adapter instance.
- Accepts one square-draw command (top-left x/y, edge size, colour) through a valid/ready handshake.
- Emits one pixel per clock on x/y/colour/plot, scanning left-to-right, then top-to-bottom.
- Clips pixels that fall outside the 160x120 frame.
- Pulses done when the square is finished, so the upstream screen FSM can sequence several boxes.

Parameters:
SCREEN_W, 160, frame width in pixels; x values >= SCREEN_W are clipped.
SCREEN_H, 120, frame height in pixels; y values >= SCREEN_H are clipped.
SIZE_W, 5, width of cmd_size; maximum edge length is 2^SIZE_W-1 (31).

Ports:
CLOCK_50  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  upstream has a command
cmd_ready  out  1  engine can accept a command this cycle
cmd_x  in  8  top-left x of square
cmd_y  in  7  top-left y of square
cmd_size  in  SIZE_W  edge length in pixels
cmd_colour  in  3  RGB colour
x  out  8  pixel x to vga_adapter
y  out  7  pixel y to vga_adapter
colour  out  3  pixel colour to vga_adapter
plot  out  1  write-enable to vga_adapter
busy  out  1  command in progress (DRAW or DONE)
done  out  1  one-cycle pulse when a command completes

Behaviour:
- One clock, CLOCK_50; reset is synchronous and active-high.
- Reset:
  - state=IDLE.
  - x=0, y=0, colour=0, plot=0, busy=0, done=0.
  - Internal counters dx=dy=0; latched command cleared.
- cmd_ready is combinational: high iff state==IDLE and reset==0.
- A command is accepted on a rising edge where cmd_valid && cmd_ready.
- On accept, the engine latches cmd_x, cmd_y, cmd_size and cmd_colour. Later changes on the cmd_* inputs have no effect.
- FSM states: IDLE, DRAW, DONE.
  - IDLE -> DRAW: on accept when cmd_size != 0.
  - IDLE -> DONE: on accept when cmd_size == 0; no pixel is plotted.
  - DRAW -> DONE: after the pixel with dx==size-1 and dy==size-1 is emitted.
  - DONE -> IDLE: unconditionally after one cycle.
- All outputs are registered.
- In DRAW, each cycle outputs:
  - px = ox+dx, computed 9 bits wide.
  - py = oy+dy, computed 8 bits wide.
  - x = px[7:0], y = py[6:0], colour = latched colour.
  - plot = 1 iff px < SCREEN_W and py < SCREEN_H.
- Clipped pixels still consume a cycle with plot=0.
- Scan order per cycle: dx increments; when dx==size-1, dx wraps to 0 and dy increments.
- Latency, with the accept edge at cycle N:
  - First pixel is valid at cycle N+1.
  - Last pixel is valid at cycle N+size².
  - done=1 at cycle N+size²+1, with plot=0.
  - cmd_ready returns at cycle N+size²+2.
- Size 0: done=1 at cycle N+1; plot stays 0 throughout.
- busy=1 in DRAW and DONE; busy=0 in IDLE.
- plot=0 in any cycle outside DRAW.
- Commands presented while busy are ignored. cmd_ready is low, and upstream must hold cmd_valid.
- Reset mid-DRAW or mid-DONE:
  - Aborts the command on that edge.
  - All outputs return to reset values; no done pulse.
  - cmd_ready is high in the next cycle if reset has deasserted.
- Maximum command (size 31) takes 961 pixel cycles + 1 done cycle.

Test Plan:
1. Reset, then cmd (x=10, y=20, size=2, colour=5) -> plot=1 on cycles N+1..N+4 with (x,y) = (10,20),(11,20),(10,21),(11,21); colour=5; done=1 only at N+5; cmd_ready=1 at N+6.
2. cmd size=0 at (40,40) -> plot never asserted; done=1 at N+1; busy=1 only at N+1.
3. Clipping: cmd (158,118), size=4 -> 16 pixel cycles.
   - plot=1 only for (158,118), (159,118), (158,119), (159,119).
   - The remaining 12 cycles have plot=0.
   - done at N+17.
4. Backpressure: second cmd_valid held high from N+1 while the first (size=3) draws -> cmd_ready=0 through N+10; second command accepted at N+11; its first pixel at N+12.
5. Reset asserted after the 3rd pixel of a size-5 box -> next cycle plot=0, x=y=colour=0, busy=0, done never pulses, cmd_ready=1 after reset drops.
6. cmd (0,0), size=31, colour=7 -> exactly 961 plot cycles; last pixel (30,30); done at N+962; no clipped pixels.
